keypad_scanner: RTL and testbench

//  Input end of the note user interface: scans a 4x4 active-low matrix keypad, debounces it, and decodes
//  key presses into the note/octave/accident triple consumed by the tone generator and 7-segment display.

---
 rtl/synth_pkg.sv | 67 ++++++
 rtl/keypad_tick.sv | 26 ++
 rtl/keypad_scanner.sv | 147 ++++++++++++++
 tb/tb_keypad_scanner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared note-interface definitions: note encodings, special key codes and the
// helpers that turn a debounced keypad frame into a priority key and a pitch.
package synth_pkg;

  localparam logic [2:0] NOTE_C = 3'd0;
  localparam logic [2:0] NOTE_D = 3'd1;
  localparam logic [2:0] NOTE_E = 3'd2;
  localparam logic [2:0] NOTE_F = 3'd3;
  localparam logic [2:0] NOTE_G = 3'd4;
  localparam logic [2:0] NOTE_A = 3'd5;
  localparam logic [2:0] NOTE_B = 3'd6;

  localparam logic [3:0] KEY_OCT_DOWN = 4'd12;
  localparam logic [3:0] KEY_OCT_UP   = 4'd13;
  localparam logic [1:0] OCTAVE_RESET = 2'd1;
  localparam logic [1:0] OCTAVE_MAX   = 2'd3;

  // valid=0 means "no usable key"; idx is forced to 0 then so codes compare cleanly.
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } key_code_t;

  typedef struct packed {
    logic [2:0] note;
    logic       sharp;
  } pitch_t;

  function automatic key_code_t priority_code(input logic [15:0] frame);
    key_code_t k;
    k = '0;
    for (int i = 15; i >= 0; i--) begin
      if (frame[i]) begin
        k.valid = 1'b1;
        k.idx   = 4'(i);
      end
    end
    // Keys 14 and 15 carry no function and behave exactly like an empty keypad.
    if (k.idx > KEY_OCT_UP) k = '0;
    return k;
  endfunction

  function automatic logic is_note(input key_code_t k);
    return k.valid && (k.idx < KEY_OCT_DOWN);
  endfunction

  function automatic pitch_t decode_pitch(input logic [3:0] idx);
    pitch_t p;
    case (idx)
      4'd0:    p = '{NOTE_C, 1'b0};
      4'd1:    p = '{NOTE_C, 1'b1};
      4'd2:    p = '{NOTE_D, 1'b0};
      4'd3:    p = '{NOTE_D, 1'b1};
      4'd4:    p = '{NOTE_E, 1'b0};
      4'd5:    p = '{NOTE_F, 1'b0};
      4'd6:    p = '{NOTE_F, 1'b1};
      4'd7:    p = '{NOTE_G, 1'b0};
      4'd8:    p = '{NOTE_G, 1'b1};
      4'd9:    p = '{NOTE_A, 1'b0};
      4'd10:   p = '{NOTE_A, 1'b1};
      4'd11:   p = '{NOTE_B, 1'b0};
      default: p = '{NOTE_C, 1'b0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// Scan-rate divider: counts 0..SCAN_DIV and asserts tick for the single cycle
// spent at SCAN_DIV, giving one tick every SCAN_DIV+1 clocks.
module keypad_tick #(
  parameter int SCAN_DIV = 200000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV);

  logic [CW-1:0] div_cnt;

  // NOTE: sequential state is assigned with <= only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= '0;
    else if (div_cnt == DIV_MAX) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row scan, frame debounce, priority decode and
// note/octave/sharp event generation for the tone generator and display.
module keypad_scanner
  import synth_pkg::*;
#(
  parameter int SCAN_DIV        = 200000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [2:0] note,
  output logic [1:0] octave,
  output logic       accident,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int DB_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_FRAMES - 1);

  logic            tick;
  logic [3:0]      col_meta, col_sync;
  logic [1:0]      row_idx;
  logic [15:0]     raw, prev, stable;
  logic            frame_done, stable_upd;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;
  key_code_t       new_code, last_code;
  pitch_t          new_pitch;

  logic [2:0] note_nxt;
  logic [1:0] octave_nxt;
  logic       accident_nxt, valid_nxt, press_nxt, release_nxt;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Columns idle high through the pull-ups, so the synchronizer resets to "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx    <= 2'd0;
      raw        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (row_idx == 2'd3);
      if (tick) begin
        raw[{row_idx, 2'b00} +: 4] <= ~col_sync;
        row_idx                    <= row_idx + 2'd1;
      end
    end
  end

  // The row is driven a whole tick period before it is sampled.
  assign row_n = ~(4'b0001 << row_idx);

  always_comb begin
    db_cnt_nxt = '0;
    if (raw == prev) db_cnt_nxt = (db_cnt == DB_LAST) ? db_cnt : db_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      stable     <= '0;
      db_cnt     <= '0;
      stable_upd <= 1'b0;
    end else begin
      stable_upd <= 1'b0;
      if (frame_done) begin
        prev   <= raw;
        db_cnt <= db_cnt_nxt;
        if (db_cnt_nxt == DB_LAST) begin
          stable     <= raw;
          stable_upd <= 1'b1;
        end
      end
    end
  end

  assign new_code  = priority_code(stable);
  assign new_pitch = decode_pitch(new_code.idx);

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    note_nxt     = note;
    accident_nxt = accident;
    octave_nxt   = octave;
    valid_nxt    = key_valid;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    // Only a change of priority code produces events; re-accepting the same code is silent.
    if (stable_upd && (new_code != last_code)) begin
      if (is_note(new_code)) begin
        note_nxt     = new_pitch.note;
        accident_nxt = new_pitch.sharp;
        valid_nxt    = 1'b1;
        press_nxt    = 1'b1;
      end else begin
        if (is_note(last_code)) begin
          valid_nxt   = 1'b0;
          release_nxt = 1'b1;
        end
        if (new_code.valid && new_code.idx == KEY_OCT_DOWN && octave != 2'd0)
          octave_nxt = octave - 2'd1;
        if (new_code.valid && new_code.idx == KEY_OCT_UP && octave != OCTAVE_MAX)
          octave_nxt = octave + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_code   <= '0;
      note        <= NOTE_C;
      accident    <= 1'b0;
      octave      <= OCTAVE_RESET;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      if (stable_upd) last_code <= new_code;
      note        <= note_nxt;
      accident    <= accident_nxt;
      octave      <= octave_nxt;
      key_valid   <= valid_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model wired to row_n/col_n, and a
// key-level reference model of the note/octave/event rules.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 3;
  localparam int DF       = 2;
  localparam int SETTLE   = 100;
  localparam int NONE     = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n, row_n;
  logic [2:0] note;
  logic [1:0] octave;
  logic       accident, key_valid, key_press, key_release;
  logic [15:0] keys = '0;

  int checks = 0, failures = 0;
  int press_total = 0, rel_total = 0, overlap_total = 0, row_bad_total = 0;

  int m_code, m_note, m_acc, m_oct, m_valid, e_press, e_rel;
  int note_tab[12]  = '{0, 0, 1, 1, 2, 3, 3, 4, 4, 5, 5, 6};
  int sharp_tab[12] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0};

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_n       (col_n),
    .row_n       (row_n),
    .note        (note),
    .octave      (octave),
    .accident    (accident),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row; a column is low when any driven row is shorted to it.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_press)   press_total++;
      if (key_release) rel_total++;
      if (key_press && key_release) overlap_total++;
      if (!(row_n inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) row_bad_total++;
    end
  end

  function automatic int code_of(input logic [15:0] k);
    for (int i = 0; i < 16; i++)
      if (k[i]) return (i >= 14) ? NONE : i;
    return NONE;
  endfunction

  task automatic model_reset();
    m_code = NONE; m_note = 0; m_acc = 0; m_oct = 1; m_valid = 0;
  endtask

  task automatic model_step(input logic [15:0] k);
    int c;
    c = code_of(k);
    e_press = 0;
    e_rel   = 0;
    if (c != m_code) begin
      if (c < 12) begin
        m_note = note_tab[c]; m_acc = sharp_tab[c]; m_valid = 1; e_press = 1;
      end else begin
        if (m_code < 12) begin m_valid = 0; e_rel = 1; end
        if (c == 12 && m_oct > 0) m_oct--;
        if (c == 13 && m_oct < 3) m_oct++;
      end
    end
    m_code = c;
  endtask

  task automatic drive_keys(input logic [15:0] k, output int dp, output int dr);
    int p0, r0;
    p0 = press_total;
    r0 = rel_total;
    model_step(k);
    keys = k;
    repeat (SETTLE) @(negedge clk);
    dp = press_total - p0;
    dr = rel_total - r0;
  endtask

  task automatic test_reset();
    logic [3:0] walk [4];
    logic [3:0] last;
    int waited;
    walk = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (row_n !== 4'b1110 || octave !== 2'd1 || note !== 3'd0 || key_valid !== 1'b0 ||
        key_press !== 1'b0 || key_release !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: row_n=%b octave=%0d note=%0d valid=%b press=%b rel=%b expected 1110 1 0 0 0 0",
               row_n, octave, note, key_valid, key_press, key_release);
    end
    rst_n = 1'b1;
    last  = row_n;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (row_n === last && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (row_n !== walk[i]) begin
        failures++;
        $display("FAIL row_walk[%0d]: row_n=%b expected %b after %0d cycles", i, row_n, walk[i], waited);
      end
      last = row_n;
    end
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic test_hold_key3();
    int dp, dr;
    drive_keys(16'h0008, dp, dr);
    checks++;
    if (dp !== 1 || dr !== 0 || note !== 3'd1 || accident !== 1'b1 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL key3_press: press=%0d rel=%0d note=%0d acc=%b valid=%b expected 1 0 1 1 1",
               dp, dr, note, accident, key_valid);
    end
    drive_keys(16'h0000, dp, dr);
    checks++;
    if (dp !== 0 || dr !== 1 || key_valid !== 1'b0 || note !== 3'd1 || accident !== 1'b1) begin
      failures++;
      $display("FAIL key3_release: press=%0d rel=%0d valid=%b note=%0d acc=%b expected 0 1 0 1 1",
               dp, dr, key_valid, note, accident);
    end
  endtask

  task automatic test_bounce();
    int p0, r0, dp, dr, waited;
    waited = 0;
    while (row_n === 4'b1101 && waited < 40) begin @(negedge clk); waited++; end
    while (row_n !== 4'b1101 && waited < 40) begin @(negedge clk); waited++; end
    p0 = press_total;
    r0 = rel_total;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h0080 : 16'h0000;
      repeat (5) @(negedge clk);
    end
    checks++;
    if (press_total - p0 !== 0 || rel_total - r0 !== 0) begin
      failures++;
      $display("FAIL bounce_quiet: press=%0d rel=%0d expected 0 0",
               press_total - p0, rel_total - r0);
    end
    drive_keys(16'h0080, dp, dr);
    checks++;
    if (dp !== 1 || dr !== 0 || note !== 3'd4 || accident !== 1'b0 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL bounce_settle: press=%0d rel=%0d note=%0d acc=%b valid=%b expected 1 0 4 0 1",
               dp, dr, note, accident, key_valid);
    end
    drive_keys(16'h0000, dp, dr);
  endtask

  task automatic test_octave();
    int dp, dr;
    int up_exp[4] = '{2, 3, 3, 3};
    int dn_exp[4] = '{2, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      drive_keys((i < 4) ? 16'h2000 : 16'h1000, dp, dr);
      checks++;
      if (octave !== 2'((i < 4) ? up_exp[i] : dn_exp[i-4]) || dp !== 0 || dr !== 0) begin
        failures++;
        $display("FAIL octave_step[%0d]: octave=%0d press=%0d rel=%0d expected %0d 0 0",
                 i, octave, dp, dr, (i < 4) ? up_exp[i] : dn_exp[i-4]);
      end
      drive_keys(16'h0000, dp, dr);
    end
  endtask

  task automatic test_chord();
    int dp, dr;
    logic [15:0] seq [4];
    int note_exp[4] = '{5, 1, 5, 5};
    int press_exp[4] = '{1, 1, 1, 0};
    seq = '{16'h0200, 16'h0204, 16'h0200, 16'h2200};
    for (int i = 0; i < 4; i++) begin
      drive_keys(seq[i], dp, dr);
      checks++;
      if (dp !== press_exp[i] || dr !== 0 || note !== 3'(note_exp[i]) ||
          octave !== 2'(m_oct) || key_valid !== 1'b1) begin
        failures++;
        $display("FAIL chord[%0d]: press=%0d rel=%0d note=%0d octave=%0d valid=%b expected %0d 0 %0d %0d 1",
                 i, dp, dr, note, octave, key_valid, press_exp[i], note_exp[i], m_oct);
      end
    end
    drive_keys(16'h0000, dp, dr);
  endtask

  task automatic test_reset_midframe();
    int dp, dr;
    drive_keys(16'h0800, dp, dr);
    repeat ($urandom_range(1, 15)) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (row_n !== 4'b1110 || note !== 3'd0 || octave !== 2'd1 || key_valid !== 1'b0 ||
        key_press !== 1'b0 || key_release !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset: row_n=%b note=%0d octave=%0d valid=%b press=%b rel=%b expected 1110 0 1 0 0 0",
               row_n, note, octave, key_valid, key_press, key_release);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_keys(16'h0800, dp, dr);
    checks++;
    if (dp !== 1 || note !== 3'd6 || accident !== 1'b0 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_repress: press=%0d note=%0d acc=%b valid=%b expected 1 6 0 1",
               dp, note, accident, key_valid);
    end
    drive_keys(16'h0000, dp, dr);
  endtask

  task automatic test_random();
    int dp, dr;
    logic [15:0] k;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       k = '0;
        1:       k = 16'(1) << $urandom_range(0, 15);
        2:       k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: k = 16'(1) << $urandom_range(0, 11);
      endcase
      drive_keys(k, dp, dr);
      checks++;
      if (dp !== e_press || dr !== e_rel || note !== 3'(m_note) || accident !== 1'(m_acc) ||
          octave !== 2'(m_oct) || key_valid !== 1'(m_valid)) begin
        failures++;
        $display("FAIL random[%0d] keys=%h: press=%0d rel=%0d note=%0d acc=%b oct=%0d valid=%b expected %0d %0d %0d %0d %0d %0d",
                 n, k, dp, dr, note, accident, octave, key_valid,
                 e_press, e_rel, m_note, m_acc, m_oct, m_valid);
      end
    end
    checks++;
    if (overlap_total !== 0 || row_bad_total !== 0) begin
      failures++;
      $display("FAIL strobe_row_sanity: overlap=%0d bad_row=%0d expected 0 0", overlap_total, row_bad_total);
    end
  endtask

  initial begin
    test_reset();
    test_hold_key3();
    test_bounce();
    test_octave();
    test_chord();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
